// File: rtl/lfsr_pkg.sv
// Shared LFSR types and the XNOR step function used by every LFSR user in this codebase.
package lfsr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } rng_state_t;

  localparam int unsigned LFSR_MAX_W = 64;

  // Caller zero-extends state/taps to LFSR_MAX_W and truncates the result back to width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] nxt;
    fb         = ~^(state & taps);
    nxt        = state >> 1;
    nxt[width-1] = fb;
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running XNOR LFSR with runtime load and all-ones lock-up recovery.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'b0000001001,
  parameter logic [WIDTH-1:0] SEED  = 10'b0011001001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic             lockup_seen
);

  logic [WIDTH-1:0] step;

  assign step = WIDTH'(lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH));

  // All-ones is the XNOR lock-up state: never let it in, recover to SEED instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEED;
      lockup_seen <= 1'b0;
    end else if (load) begin
      if (&load_value) begin
        state       <= SEED;
        lockup_seen <= 1'b1;
      end else begin
        state <= load_value;
      end
    end else if (&state) begin
      state       <= SEED;
      lockup_seen <= 1'b1;
    end else begin
      state <= step;
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Uniform random value in [0, RANGE-1] drawn from an LFSR by bounded rejection sampling.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS      = 10'b0000001001,
  parameter logic [WIDTH-1:0] SEED      = 10'b0011001001,
  parameter int unsigned      RANGE     = 10,
  parameter int unsigned      MAX_TRIES = 8,
  localparam int unsigned     OUT_W     = $clog2(RANGE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup_seen
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  rng_state_t       fsm, fsm_nxt;
  logic [TRY_W-1:0] tries, tries_nxt;
  logic [OUT_W-1:0] rand_nxt;
  logic             valid_nxt;
  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic             last_try;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .load        (seed_load),
    .load_value  (seed_in),
    .state       (state_out),
    .lockup_seen (lockup_seen)
  );

  assign cand     = state_out[OUT_W-1:0];
  assign cand_ok  = 32'(cand) < RANGE;
  assign last_try = tries == TRY_W'(MAX_TRIES - 1);
  assign ready    = (fsm == IDLE);

  // Fold fallback: OUT_W = clog2(RANGE) keeps cand below 2*RANGE, so cand-RANGE is in range.
  always_comb begin
    fsm_nxt   = fsm;
    tries_nxt = tries;
    rand_nxt  = rand_out;
    valid_nxt = 1'b0;
    case (fsm)
      IDLE: begin
        if (req) begin
          fsm_nxt   = DRAW;
          tries_nxt = '0;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          rand_nxt  = cand;
          valid_nxt = 1'b1;
          fsm_nxt   = IDLE;
        end else if (last_try) begin
          rand_nxt  = OUT_W'(32'(cand) - RANGE);
          valid_nxt = 1'b1;
          fsm_nxt   = IDLE;
        end else begin
          tries_nxt = tries + 1'b1;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= IDLE;
      tries    <= '0;
      rand_out <= '0;
      valid    <= 1'b0;
    end else begin
      fsm      <= fsm_nxt;
      tries    <= tries_nxt;
      rand_out <= rand_nxt;
      valid    <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: default instance plus a MAX_TRIES=1 instance on shared stimulus.
module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [9:0] seed_in = '0;
  logic       req = 1'b0;

  logic       ready0, valid0, lock0;
  logic [3:0] rand0;
  logic [9:0] state0;
  logic       ready1, valid1, lock1;
  logic [3:0] rand1;
  logic [9:0] state1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rand_gen dut0 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .ready(ready0), .valid(valid0), .rand_out(rand0), .state_out(state0), .lockup_seen(lock0)
  );

  lfsr_rand_gen #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .ready(ready1), .valid(valid1), .rand_out(rand1), .state_out(state1), .lockup_seen(lock1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // After this the current cycle is cycle 0 with state SEED.
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [9:0] seq [0:5];
    int         nvalid;
    logic [3:0] got [0:2];
    seq[0] = 10'h0C9; seq[1] = 10'h264; seq[2] = 10'h332;
    seq[3] = 10'h399; seq[4] = 10'h3CC; seq[5] = 10'h1E6;

    // Reset values and free-running sequence
    do_reset();
    chk("rst_state", 32'(state0), 32'h0C9);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_rand",  32'(rand0),  32'd0);
    chk("rst_lock",  32'(lock0),  32'd0);
    for (int k = 1; k < 6; k++) begin
      step();
      chk($sformatf("seq_%0d", k), 32'(state0), 32'(seq[k]));
    end

    // First-try acceptance: req with state 0x0C9, DRAW sees 0x264 -> 4
    do_reset();
    req = 1'b1;
    step();
    req = 1'b0;
    chk("acc_ready_draw", 32'(ready0), 32'd0);
    chk("acc_valid_n1",   32'(valid0), 32'd0);
    step();
    chk("acc_valid_n2", 32'(valid0), 32'd1);
    chk("acc_rand",     32'(rand0),  32'd4);
    chk("acc_ready_n2", 32'(ready0), 32'd1);
    step();
    chk("acc_valid_drop", 32'(valid0), 32'd0);
    chk("acc_rand_hold",  32'(rand0),  32'd4);

    // One rejection (12) then 6; MAX_TRIES=1 folds 12 to 2
    do_reset();
    step(); step(); step();
    chk("rej_pre_state", 32'(state0), 32'h399);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("rej_valid_n1",  32'(valid0), 32'd0);
    chk("fold_valid_n1", 32'(valid1), 32'd0);
    step();
    chk("rej_valid_n2",  32'(valid0), 32'd0);
    chk("rej_ready_n2",  32'(ready0), 32'd0);
    chk("fold_valid_n2", 32'(valid1), 32'd1);
    chk("fold_rand",     32'(rand1),  32'd2);
    step();
    chk("rej_valid_n3",  32'(valid0), 32'd1);
    chk("rej_rand",      32'(rand0),  32'd6);
    chk("fold_valid_n3", 32'(valid1), 32'd0);

    // Lock-up interception and normal reseed
    seed_in = 10'h3FF;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("lock_state", 32'(state0), 32'h0C9);
    chk("lock_seen",  32'(lock0),  32'd1);
    step();
    chk("lock_state_next", 32'(state0), 32'h264);
    seed_in = 10'h155;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("load_state", 32'(state0), 32'h155);
    chk("lock_sticky", 32'(lock0), 32'd1);
    step();
    chk("load_next", 32'(state0), 32'h0AA);

    // Reset mid-DRAW drops the pending request
    do_reset();
    step(); step(); step();
    req = 1'b1;
    step();
    req = 1'b0;
    chk("mid_in_draw", 32'(ready0), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_ready", 32'(ready0), 32'd1);
    chk("mid_valid", 32'(valid0), 32'd0);
    chk("mid_rand",  32'(rand0),  32'd0);
    chk("mid_state", 32'(state0), 32'h0C9);
    chk("mid_lock",  32'(lock0),  32'd0);
    step();
    reset = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (valid0 || valid1) nvalid++;
    end
    chk("mid_no_valid", 32'(nvalid), 32'd0);

    // req held 5 cycles: accepted in cycles 0,2,4 -> results 4,9,6 and nothing queued
    do_reset();
    req = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5) req = 1'b0;
      if (valid0) begin
        if (nvalid < 3) got[nvalid] = rand0;
        nvalid++;
      end
    end
    req = 1'b0;
    chk("held_count", 32'(nvalid), 32'd3);
    chk("held_val0",  32'(got[0]), 32'd4);
    chk("held_val1",  32'(got[1]), 32'd9);
    chk("held_val2",  32'(got[2]), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
